// File: rtl/decode_split_rp.sv
// Purpose: one level of rounded-polynomial decode. For each pair k it forms
//   r = R2[k]*256^bot + bottom bytes (little-endian) and writes
//   R[2k] = r mod M0, R[2k+1] = (r div M0) mod M1. For odd-length levels the
//   last R2 entry is copied through to R[2*pairs].
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start / done         level kick-off (sampled in IDLE) / one-cycle completion
//   param_*              level parameters, latched on start
//   r2_rd_addr/data      R2 source buffer (registered read, 1-cycle latency)
//   cd_rd_addr/data      ciphertext byte buffer (registered read, 1-cycle latency)
//   rp_wr_addr/data/en   R destination write port
//   cd_next_addr         byte address after the last consumed byte, valid with done
module decode_split_rp #(
    parameter int unsigned RP_DEPTH   = 10,
    parameter int unsigned RP_D_SIZE  = 16,
    parameter int unsigned OUT_DEPTH  = 11,
    parameter int unsigned OUT_D_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [RP_D_SIZE-1:0]  param_m0,
    input  logic [RP_D_SIZE-1:0]  param_m1,
    input  logic [1:0]            param_bot,
    input  logic [RP_DEPTH-1:0]   param_pairs,
    input  logic                  param_odd,
    input  logic [OUT_DEPTH-1:0]  param_cd_base,
    output logic [RP_DEPTH-1:0]   r2_rd_addr,
    input  logic [RP_D_SIZE-1:0]  r2_rd_data,
    output logic [OUT_DEPTH-1:0]  cd_rd_addr,
    input  logic [OUT_D_SIZE-1:0] cd_rd_data,
    output logic [RP_DEPTH-1:0]   rp_wr_addr,
    output logic [RP_D_SIZE-1:0]  rp_wr_data,
    output logic                  rp_wr_en,
    output logic [OUT_DEPTH-1:0]  cd_next_addr
);

    localparam int unsigned ACC_W = 30;
    localparam int unsigned REM_W = RP_D_SIZE + 1;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_R2, S_RD_B, S_DIV0, S_DIV1,
        S_WR0, S_WR1, S_ODD_RD, S_ODD_WR, S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [RP_D_SIZE-1:0]   m0_q, m0_d, m1_q, m1_d;
    logic [1:0]             bot_q, bot_d;
    logic [RP_DEPTH-1:0]    pairs_q, pairs_d;
    logic                   odd_q, odd_d;
    logic [OUT_DEPTH-1:0]   base_q, base_d;
    logic [RP_DEPTH-1:0]    k_q, k_d;
    logic                   byte_idx_q, byte_idx_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [RP_D_SIZE-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RP_D_SIZE-1:0]   r0_q, r0_d, r1_q, r1_d;
    logic                   done_q, done_d;
    logic [RP_DEPTH-1:0]    r2_rd_addr_q, r2_rd_addr_d;
    logic [OUT_DEPTH-1:0]   cd_rd_addr_q, cd_rd_addr_d;
    logic [RP_DEPTH-1:0]    rp_wr_addr_q, rp_wr_addr_d;
    logic [RP_D_SIZE-1:0]   rp_wr_data_q, rp_wr_data_d;
    logic                   rp_wr_en_q, rp_wr_en_d;
    logic [OUT_DEPTH-1:0]   cd_next_addr_q, cd_next_addr_d;

    // Divider datapath and helpers
    logic [REM_W-1:0]       rem_sh, rem_nx;
    logic [RP_D_SIZE-1:0]   div_m;
    logic                   ge;
    logic [ACC_W-1:0]       acc_nx;
    logic [RP_DEPTH-1:0]    k_nx;
    logic [OUT_DEPTH-1:0]   cd_next_c;

    assign done         = done_q;
    assign r2_rd_addr   = r2_rd_addr_q;
    assign cd_rd_addr   = cd_rd_addr_q;
    assign rp_wr_addr   = rp_wr_addr_q;
    assign rp_wr_data   = rp_wr_data_q;
    assign rp_wr_en     = rp_wr_en_q;
    assign cd_next_addr = cd_next_addr_q;

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        m0_d           = m0_q;
        m1_d           = m1_q;
        bot_d          = bot_q;
        pairs_d        = pairs_q;
        odd_d          = odd_q;
        base_d         = base_q;
        k_d            = k_q;
        byte_idx_d     = byte_idx_q;
        acc_d          = acc_q;
        rem_d          = rem_q;
        cnt_d          = cnt_q;
        r0_d           = r0_q;
        r1_d           = r1_q;
        done_d         = 1'b0;
        r2_rd_addr_d   = r2_rd_addr_q;
        cd_rd_addr_d   = cd_rd_addr_q;
        rp_wr_addr_d   = rp_wr_addr_q;
        rp_wr_data_d   = rp_wr_data_q;
        rp_wr_en_d     = 1'b0;
        cd_next_addr_d = cd_next_addr_q;

        // Restoring division step: acc shifts out dividend bits and in quotient bits
        div_m  = (state_q == S_DIV1) ? m1_q : m0_q;
        rem_sh = {rem_q, acc_q[ACC_W-1]};
        ge     = (rem_sh >= REM_W'(div_m));
        rem_nx = ge ? REM_W'(rem_sh - REM_W'(div_m)) : rem_sh;
        acc_nx = {acc_q[ACC_W-2:0], ge};

        k_nx      = RP_DEPTH'(k_q + RP_DEPTH'(1));
        cd_next_c = OUT_DEPTH'(32'(base_q) + 32'(pairs_q) * 32'(bot_q));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m0_d         = param_m0;
                    m1_d         = param_m1;
                    bot_d        = (param_bot == 2'd3) ? 2'd2 : param_bot;
                    pairs_d      = param_pairs;
                    odd_d        = param_odd;
                    base_d       = param_cd_base;
                    k_d          = '0;
                    phase_d      = 1'b0;
                    byte_idx_d   = 1'b0;
                    cd_rd_addr_d = param_cd_base;
                    r2_rd_addr_d = '0;
                    if (param_pairs != '0) begin
                        state_d = S_RD_R2;
                    end else if (param_odd) begin
                        state_d = S_ODD_RD;
                    end else begin
                        done_d         = 1'b1;
                        cd_next_addr_d = param_cd_base;
                        state_d        = S_FIN;
                    end
                end
            end
            S_RD_R2: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    byte_idx_d = 1'b0;
                    // Pre-shift R2 so bottom bytes can be OR-ed into the low bits
                    case (bot_q)
                        2'd0:    acc_d = ACC_W'(r2_rd_data);
                        2'd1:    acc_d = ACC_W'({r2_rd_data, 8'h00});
                        default: acc_d = ACC_W'({r2_rd_data, 16'h0000});
                    endcase
                    if (bot_q == 2'd0) begin
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV0;
                    end else begin
                        state_d = S_RD_B;
                    end
                end
            end
            S_RD_B: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d      = 1'b0;
                    acc_d        = byte_idx_q ? (acc_q | ACC_W'({cd_rd_data, 8'h00}))
                                              : (acc_q | ACC_W'(cd_rd_data));
                    cd_rd_addr_d = OUT_DEPTH'(cd_rd_addr_q + OUT_DEPTH'(1));
                    if (!byte_idx_q && (bot_q == 2'd2)) begin
                        byte_idx_d = 1'b1;
                    end else begin
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV0;
                    end
                end
            end
            S_DIV0, S_DIV1: begin
                acc_d = acc_nx;
                rem_d = RP_D_SIZE'(rem_nx);
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(ACC_W - 1)) begin
                    rem_d = '0;
                    cnt_d = '0;
                    if (state_q == S_DIV0) begin
                        // Quotient stays in acc as the next dividend
                        r0_d    = RP_D_SIZE'(rem_nx);
                        state_d = S_DIV1;
                    end else begin
                        r1_d         = RP_D_SIZE'(rem_nx);
                        rp_wr_en_d   = 1'b1;
                        rp_wr_addr_d = RP_DEPTH'({k_q, 1'b0});
                        rp_wr_data_d = r0_q;
                        state_d      = S_WR0;
                    end
                end
            end
            S_WR0: begin
                rp_wr_en_d   = 1'b1;
                rp_wr_addr_d = RP_DEPTH'({k_q, 1'b1});
                rp_wr_data_d = r1_q;
                state_d      = S_WR1;
            end
            S_WR1: begin
                k_d = k_nx;
                if (k_nx == pairs_q) begin
                    if (odd_q) begin
                        r2_rd_addr_d = pairs_q;
                        state_d      = S_ODD_RD;
                    end else begin
                        done_d         = 1'b1;
                        cd_next_addr_d = cd_next_c;
                        state_d        = S_FIN;
                    end
                end else begin
                    r2_rd_addr_d = k_nx;
                    state_d      = S_RD_R2;
                end
            end
            S_ODD_RD: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d      = 1'b0;
                    rp_wr_en_d   = 1'b1;
                    rp_wr_addr_d = RP_DEPTH'({pairs_q, 1'b0});
                    rp_wr_data_d = r2_rd_data;
                    state_d      = S_ODD_WR;
                end
            end
            S_ODD_WR: begin
                done_d         = 1'b1;
                cd_next_addr_d = cd_next_c;
                state_d        = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            phase_q        <= 1'b0;
            m0_q           <= '0;
            m1_q           <= '0;
            bot_q          <= '0;
            pairs_q        <= '0;
            odd_q          <= 1'b0;
            base_q         <= '0;
            k_q            <= '0;
            byte_idx_q     <= 1'b0;
            acc_q          <= '0;
            rem_q          <= '0;
            cnt_q          <= '0;
            r0_q           <= '0;
            r1_q           <= '0;
            done_q         <= 1'b0;
            r2_rd_addr_q   <= '0;
            cd_rd_addr_q   <= '0;
            rp_wr_addr_q   <= '0;
            rp_wr_data_q   <= '0;
            rp_wr_en_q     <= 1'b0;
            cd_next_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            m0_q           <= m0_d;
            m1_q           <= m1_d;
            bot_q          <= bot_d;
            pairs_q        <= pairs_d;
            odd_q          <= odd_d;
            base_q         <= base_d;
            k_q            <= k_d;
            byte_idx_q     <= byte_idx_d;
            acc_q          <= acc_d;
            rem_q          <= rem_d;
            cnt_q          <= cnt_d;
            r0_q           <= r0_d;
            r1_q           <= r1_d;
            done_q         <= done_d;
            r2_rd_addr_q   <= r2_rd_addr_d;
            cd_rd_addr_q   <= cd_rd_addr_d;
            rp_wr_addr_q   <= rp_wr_addr_d;
            rp_wr_data_q   <= rp_wr_data_d;
            rp_wr_en_q     <= rp_wr_en_d;
            cd_next_addr_q <= cd_next_addr_d;
        end
    end

endmodule
